// File: rtl/dma_scheduler.sv
// Round-robin command scheduler in front of the single-transfer DMA engine.
// Latches one descriptor at a time, drives the engine, and reports completion/error per requester.
module dma_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 16,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_dir,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  output logic [NUM_REQ-1:0]          cmp_valid,
  output logic                        cmp_err,
  output logic                        dma_start,
  output logic                        dma_write_en,
  output logic [ADDR_W-1:0]           dma_base_addr,
  output logic [LEN_W-1:0]            dma_length,
  input  logic                        dma_done,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int GNT_W = $clog2(NUM_REQ);
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SUM_W-1:0] ADDR_SPAN = SUM_W'(1) << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMPLETE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [GNT_W-1:0]    r_last_grant;
  logic [GNT_W-1:0]    r_grant_id;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_write_en;
  logic [ADDR_W-1:0]   r_base_addr;
  logic [LEN_W-1:0]    r_length;

  logic [GNT_W-1:0]    w_idx;
  logic [GNT_W-1:0]    w_winner;
  logic                w_found;
  logic                w_sel_dir;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [LEN_W-1:0]    w_sel_len;
  logic [SUM_W-1:0]    w_end_addr;
  logic                w_bad_desc;
  logic                w_timeout_hit;

  // Search starts one past the last served requester so the previous winner goes last.
  // NOTE: every always_comb output gets a default first; a missed path would infer a latch.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = GNT_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_dir  = 1'b0;
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == GNT_W'(i)) begin
        w_sel_dir  = req_dir[i];
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_len  = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // End address is formed one bit wider than either operand so it cannot wrap.
  assign w_end_addr    = SUM_W'(w_sel_addr) + SUM_W'(w_sel_len);
  assign w_bad_desc    = (w_sel_len == '0) || (w_end_addr > ADDR_SPAN);
  assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    dma_start    = 1'b0;
    cmp_valid    = '0;
    cmp_err      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready[w_winner] = reset;
          w_next_state        = w_bad_desc ? S_COMPLETE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        dma_start    = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (dma_done || w_timeout_hit) w_next_state = S_COMPLETE;
      end
      S_COMPLETE: begin
        cmp_valid[r_grant_id] = 1'b1;
        cmp_err               = r_err;
        w_next_state          = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= GNT_W'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_write_en   <= 1'b0;
      r_base_addr  <= '0;
      r_length     <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant_id  <= w_winner;
            r_write_en  <= w_sel_dir;
            r_base_addr <= w_sel_addr;
            r_length    <= w_sel_len;
            r_err       <= w_bad_desc;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          // A done on the last counted cycle still wins over the timeout.
          if (dma_done)           r_err <= 1'b0;
          else if (w_timeout_hit) r_err <= 1'b1;
          else                    r_cnt <= r_cnt + CNT_W'(1);
        end
        S_COMPLETE: r_last_grant <= r_grant_id;
        default: ;
      endcase
    end
  end

  assign dma_write_en  = r_write_en;
  assign dma_base_addr = r_base_addr;
  assign dma_length    = r_length;
  assign busy          = (r_state != S_IDLE);
  assign grant_id      = r_grant_id;

endmodule

// File: tb/tb_dma_scheduler.sv
// Scoreboard bench for dma_scheduler: a transaction-level model predicts grants, engine
// issues and completions; a monitor pops and compares whenever the DUT presents them.
module tb_dma_scheduler;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 8;
  localparam int LEN_W   = 16;
  localparam int TC      = 16;
  localparam int GW      = $clog2(NUM_REQ);

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_dir = '0;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr = '0;
  logic [NUM_REQ*LEN_W-1:0]   req_len = '0;
  logic [NUM_REQ-1:0]         cmp_valid;
  logic                       cmp_err;
  logic                       dma_start;
  logic                       dma_write_en;
  logic [ADDR_W-1:0]          dma_base_addr;
  logic [LEN_W-1:0]           dma_length;
  logic                       dma_done = 1'b0;
  logic                       busy;
  logic [GW-1:0]              grant_id;

  dma_scheduler #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TC)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_addr(req_addr), .req_len(req_len),
    .cmp_valid(cmp_valid), .cmp_err(cmp_err),
    .dma_start(dma_start), .dma_write_en(dma_write_en),
    .dma_base_addr(dma_base_addr), .dma_length(dma_length),
    .dma_done(dma_done), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int id; bit dir; int addr; int len; int cyc; } issue_t;
  typedef struct { int id; bit err; int cyc; } cmp_t;

  issue_t iss_q[$];
  cmp_t   cmp_q[$];
  int     eng_q[$];
  int     m_last = NUM_REQ - 1;
  int     m_busy_until = -1;
  int     m_accepts = 0;
  int     next_delay = 2;   // engine done latency after start; <=0 means withheld

  // Reference model: transaction rules only (round-robin pick, bounds rule, latency rule).
  always @(negedge clk) begin : model
    int w, a, l, t, d;
    bit e;
    logic [NUM_REQ-1:0] exp_rdy;
    if (!reset) begin
      iss_q.delete(); cmp_q.delete(); eng_q.delete();
      m_last = NUM_REQ - 1;
      m_busy_until = -1;
    end else begin
      check("busy", busy, 64'(cyc <= m_busy_until));
      w = -1;
      exp_rdy = '0;
      if (cyc > m_busy_until)
        for (int k = 1; k <= NUM_REQ; k++)
          if (w < 0 && req_valid[(m_last + k) % NUM_REQ]) w = (m_last + k) % NUM_REQ;
      if (w >= 0) exp_rdy[w] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      if (w >= 0) begin
        a = int'(req_addr[w*ADDR_W +: ADDR_W]);
        l = int'(req_len[w*LEN_W +: LEN_W]);
        e = (l == 0) || (a + l > (1 << ADDR_W));
        t = cyc;
        d = next_delay;
        if (e) cmp_q.push_back('{w, 1'b1, t + 1});
        else begin
          iss_q.push_back('{w, req_dir[w], a, l, t + 1});
          eng_q.push_back(d);
          if (d >= 1 && d <= TC) cmp_q.push_back('{w, 1'b0, t + 1 + d + 1});
          else                   cmp_q.push_back('{w, 1'b1, t + 2 + TC});
        end
        m_busy_until = cmp_q[$].cyc;
        m_last = w;
        m_accepts++;
      end
    end
  end

  always @(negedge clk) begin : monitor
    issue_t it;
    cmp_t cp;
    logic [NUM_REQ-1:0] oh;
    if (reset) begin
      if (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
        check("start_missing", cyc, iss_q[0].cyc);
        void'(iss_q.pop_front());
      end
      if (cmp_q.size() > 0 && cmp_q[0].cyc < cyc) begin
        check("cmp_missing", cyc, cmp_q[0].cyc);
        void'(cmp_q.pop_front());
      end
      if (dma_start) begin
        if (iss_q.size() == 0) check("spurious_start", dma_start, 0);
        else begin
          it = iss_q.pop_front();
          check("start_cycle", cyc, it.cyc);
          check("write_en", dma_write_en, it.dir);
          check("base_addr", dma_base_addr, it.addr);
          check("length", dma_length, it.len);
          check("start_grant", grant_id, it.id);
        end
      end
      if (cmp_valid != '0) begin
        if (cmp_q.size() == 0) check("spurious_cmp", cmp_valid, 0);
        else begin
          cp = cmp_q.pop_front();
          oh = '0;
          oh[cp.id] = 1'b1;
          check("cmp_valid", cmp_valid, oh);
          check("cmp_err", cmp_err, cp.err);
          check("cmp_cycle", cyc, cp.cyc);
          check("cmp_grant", grant_id, cp.id);
        end
      end
    end
  end

  // Engine stand-in: answers each start after the latency the model chose for it.
  initial begin : engine
    int d;
    forever begin
      @(negedge clk);
      if (reset && dma_start && eng_q.size() > 0) begin
        d = eng_q.pop_front();
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1 dma_done = reset;
          @(posedge clk);
          #1 dma_done = 1'b0;
        end
      end
    end
  end

  task automatic set_req(input int i, input bit dir, input int addr, input int len);
    req_dir[i] = dir;
    req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic rand_desc(input int i);
    int a, l;
    a = ($urandom_range(1, 0) == 1) ? int'($urandom_range(255, 0)) : int'($urandom_range(255, 240));
    case ($urandom_range(3, 0))
      0:       l = 0;
      1:       l = int'($urandom_range(16, 1));
      2:       l = int'($urandom_range(300, 1));
      default: l = int'($urandom_range(65535, 1));
    endcase
    set_req(i, 1'($urandom_range(1, 0)), a, l);
  endtask

  task automatic wait_accept(output int g);
    int prev = m_accepts;
    bit got = 1'b0;
    for (int n = 0; n < 80 && !got; n++) begin
      @(posedge clk);
      #1;
      got = (m_accepts != prev);
    end
    check("accept_bound", got, 1);
    g = m_last;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int n = 0; n < 100 && !idle; n++) begin
      @(posedge clk);
      #1;
      idle = (cyc > m_busy_until) && (iss_q.size() == 0) && (cmp_q.size() == 0);
    end
    check("idle_bound", idle, 1);
  endtask

  task automatic issue_one(input int i, input bit dir, input int addr, input int len, input int delay);
    int g;
    next_delay = delay;
    set_req(i, dir, addr, len);
    req_valid = '0;
    req_valid[i] = 1'b1;
    wait_accept(g);
    req_valid = '0;
    wait_idle();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int g;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'h11 * (i + 1), i + 1);
    req_valid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_cmp_valid", cmp_valid, 0);
    check("rst_cmp_err", cmp_err, 0);
    check("rst_dma_start", dma_start, 0);
    check("rst_write_en", dma_write_en, 0);
    check("rst_base_addr", dma_base_addr, 0);
    check("rst_length", dma_length, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    req_valid = '0;
    @(posedge clk);
    #1 reset = 1'b1;

    issue_one(0, 1'b1, 'h10, 4, 6);        // single load
    issue_one(1, 1'b0, 'h20, 0, 2);        // zero length, rejected

    next_delay = 2;                        // round-robin with all requesters held valid
    for (int i = 0; i < NUM_REQ; i++) set_req(i, i[0], 'h10 * (i + 1), i + 1);
    req_valid = '1;
    for (int n = 0; n < 6; n++) begin
      wait_accept(g);
      set_req(g, 1'($urandom_range(1, 0)), int'($urandom_range(200, 0)), int'($urandom_range(40, 1)));
    end
    req_valid = '0;
    wait_idle();

    issue_one(2, 1'b1, 'h30, 8, 19);       // timeout, late done two cycles after completion
    repeat (4) @(posedge clk);
    #1;
    issue_one(0, 1'b0, 'h40, 3, 3);
    issue_one(1, 1'b1, 'h50, 2, TC);       // done on the final counted cycle
    issue_one(2, 1'b0, 'h60, 2, TC + 1);   // one cycle too late

    issue_one(0, 1'b1, 'hFE, 4, 2);        // bounds
    issue_one(1, 1'b1, 'hFC, 4, 2);
    issue_one(2, 1'b0, 'h00, 256, 2);
    issue_one(0, 1'b0, 'h00, 257, 2);
    issue_one(1, 1'b0, 'hFF, 'hFFFF, 2);
    issue_one(2, 1'b1, 'hFF, 1, 1);

    req_valid = '0;                        // randomized traffic
    for (int n = 0; n < 40; n++) begin
      next_delay = int'($urandom_range(TC + 2, 1));
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          rand_desc(i);
          req_valid[i] = 1'b1;
        end
      if (req_valid == '0) begin
        rand_desc(0);
        req_valid[0] = 1'b1;
      end
      wait_accept(g);
      if ($urandom_range(1, 0) == 1) rand_desc(g);
      else req_valid[g] = 1'b0;
    end
    req_valid = '0;
    wait_idle();
    repeat (TC + 4) @(posedge clk);
    #1;

    issue_one(1, 1'b1, 'h08, 8, 2);        // make last grant 1 before the reset
    next_delay = -1;                       // reset during WAIT
    set_req(2, 1'b1, 'h70, 5);
    req_valid = 3'b100;
    wait_accept(g);
    req_valid = '0;
    repeat (5) @(posedge clk);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 'h20 + i, 2);
    req_valid = '1;
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_cmp_valid", cmp_valid, 0);
    check("mid_rst_dma_start", dma_start, 0);
    check("mid_rst_write_en", dma_write_en, 0);
    check("mid_rst_base_addr", dma_base_addr, 0);
    check("mid_rst_length", dma_length, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant_id", grant_id, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    next_delay = 3;
    wait_accept(g);
    req_valid = '0;
    wait_idle();

    check("iss_q_empty", iss_q.size(), 0);
    check("cmp_q_empty", cmp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
